duty_button_conditioner: RTL and testbench

//  Upstream stage of the PWM duty-cycle controller. Converts two raw, bouncing push-button

---
 rtl/duty_button_conditioner_pkg.sv | 25 ++
 rtl/duty_button_conditioner_if.sv | 22 ++
 rtl/duty_button_conditioner_button_channel.sv | 132 +++++++++++++
 rtl/duty_button_conditioner.sv | 71 +++++++
 tb/tb_duty_button_conditioner.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/duty_button_conditioner_pkg.sv
// Shared types and default constants for the duty-cycle button front end.
// State encodings and defaults are also used by the PWM stage build switch.
package duty_button_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_HELD    = 3'd2,
        ST_REPEAT  = 3'd3,
        ST_RELEASE = 3'd4
    } btn_state_e;

    localparam int DEF_TICK_DIV       = 4;
    localparam int DEF_STABLE_SAMPLES = 3;
    localparam int DEF_REPEAT_DELAY   = 8;
    localparam int DEF_REPEAT_RATE    = 2;
    localparam int DEF_REPEAT_EN      = 1;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/duty_button_conditioner_if.sv
// Raw button inputs and conditioned step outputs of the button front end.
// The master side drives the buttons; the slave side is the conditioner.
interface duty_button_conditioner_if;

    logic btn_inc_raw;
    logic btn_dec_raw;
    logic inc_pulse;
    logic dec_pulse;
    logic inc_held;
    logic dec_held;

    modport master (
        output btn_inc_raw, btn_dec_raw,
        input  inc_pulse, dec_pulse, inc_held, dec_held
    );

    modport slave (
        input  btn_inc_raw, btn_dec_raw,
        output inc_pulse, dec_pulse, inc_held, dec_held
    );

endinterface

// File: rtl/duty_button_conditioner_button_channel.sv
// One button: 2-FF synchroniser, tick-rate debounce FSM and auto-repeat.
// req is a one-tick step request; held is the registered debounced level.
module button_channel
    import duty_button_conditioner_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
    parameter int REPEAT_EN      = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic req,
    output logic held
);

    localparam int CW =
        $clog2(max3(STABLE_SAMPLES, REPEAT_DELAY, REPEAT_RATE)) + 1;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t SS_C = cnt_t'(STABLE_SAMPLES);
    localparam cnt_t RD_C = cnt_t'(REPEAT_DELAY);
    localparam cnt_t RR_C = cnt_t'(REPEAT_RATE);

    // A single-sample debounce skips the CONFIRM and RELEASE states.
    localparam bit         ONE_SMP = (STABLE_SAMPLES == 1);
    localparam btn_state_e PRS_ST  = ONE_SMP ? ST_HELD : ST_CONFIRM;
    localparam btn_state_e REL_ST  = ONE_SMP ? ST_IDLE : ST_RELEASE;
    localparam cnt_t       ENT_CNT = ONE_SMP ? cnt_t'(0) : cnt_t'(1);

    logic [1:0] sync_q;
    logic       samp;
    btn_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d, cnt_inc;
    logic       held_q;

    assign samp    = sync_q[1];
    assign cnt_inc = cnt_q + cnt_t'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b00;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= state_d inside {ST_HELD, ST_REPEAT, ST_RELEASE};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (samp) begin
                        state_d = PRS_ST;
                        cnt_d   = ENT_CNT;
                    end
                end
                ST_CONFIRM: begin
                    if (!samp) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == SS_C) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!samp) begin
                        state_d = REL_ST;
                        cnt_d   = ENT_CNT;
                    end else if (REPEAT_EN != 0 && cnt_inc == RD_C) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                    end else if (cnt_inc != RD_C) begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_REPEAT: begin
                    if (!samp) begin
                        state_d = REL_ST;
                        cnt_d   = ENT_CNT;
                    end else if (cnt_inc == RR_C) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (samp) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == SS_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        req  = 1'b0;
        held = held_q;
        if (tick && samp) begin
            unique case (state_q)
                ST_IDLE:    req = ONE_SMP;
                ST_CONFIRM: req = (cnt_inc == SS_C);
                ST_HELD:    req = (REPEAT_EN != 0) && (cnt_inc == RD_C);
                ST_REPEAT:  req = (cnt_inc == RR_C);
                default:    req = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/duty_button_conditioner.sv
// Button front end of the PWM duty controller: shared sample-tick prescaler,
// two debounced channels, opposite-step lockout and registered step pulses.
module duty_button_conditioner
    import duty_button_conditioner_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
    parameter int REPEAT_EN      = DEF_REPEAT_EN
) (
    input logic                       clk,
    input logic                       reset,
    duty_button_conditioner_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    typedef logic [PW-1:0] pre_t;

    pre_t pre_q;
    logic tick;
    logic req_inc, req_dec;
    logic inc_pulse_q, dec_pulse_q;

    assign tick = (pre_q == pre_t'(TICK_DIV - 1));

    // Simultaneous opposite requests cancel; channels keep advancing.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
        end else begin
            pre_q       <= tick ? '0 : pre_q + pre_t'(1);
            inc_pulse_q <= req_inc & ~req_dec;
            dec_pulse_q <= req_dec & ~req_inc;
        end
    end

    button_channel #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (REPEAT_EN)
    ) u_inc (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .btn_raw (bus.btn_inc_raw),
        .req     (req_inc),
        .held    (bus.inc_held)
    );

    button_channel #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (REPEAT_EN)
    ) u_dec (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .btn_raw (bus.btn_dec_raw),
        .req     (req_dec),
        .held    (bus.dec_held)
    );

    assign bus.inc_pulse = inc_pulse_q;
    assign bus.dec_pulse = dec_pulse_q;

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Bench for duty_button_conditioner: auto-repeat and single-shot builds
// driven with the same buttons and checked against a run-length model.
module tb_duty_button_conditioner;
    import duty_button_conditioner_pkg::*;

    localparam int TD = DEF_TICK_DIV;
    localparam int SS = DEF_STABLE_SAMPLES;
    localparam int RD = DEF_REPEAT_DELAY;
    localparam int RR = DEF_REPEAT_RATE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_inc = 1'b0;
    logic btn_dec = 1'b0;

    duty_button_conditioner_if bus0 ();
    duty_button_conditioner_if bus1 ();

    assign bus0.btn_inc_raw = btn_inc;
    assign bus0.btn_dec_raw = btn_dec;
    assign bus1.btn_inc_raw = btn_inc;
    assign bus1.btn_dec_raw = btn_dec;

    duty_button_conditioner #(
        .TICK_DIV(TD), .STABLE_SAMPLES(SS), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .REPEAT_EN(1)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    duty_button_conditioner #(
        .TICK_DIV(TD), .STABLE_SAMPLES(SS), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .REPEAT_EN(0)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: [build][channel], build 0 repeats, channel 0 is inc.
    int ncyc;
    bit d1 [2];
    bit d2 [2];
    bit lvl [2][2];
    int run [2][2];
    int rl  [2][2];
    int hld [2][2];
    bit exp_p [2][2];
    bit exp_h [2][2];
    int pc [2][2];

    function automatic void model_reset();
        ncyc = 0;
        for (int c = 0; c < 2; c++) begin
            d1[c] = 0;
            d2[c] = 0;
            for (int i = 0; i < 2; i++) begin
                lvl[i][c] = 0; run[i][c] = 0; rl[i][c] = 0;
                hld[i][c] = 0; exp_p[i][c] = 0; exp_h[i][c] = 0;
            end
        end
    endfunction

    // Debounced level flips after SS equal samples; press time drives repeat.
    function automatic bit model_tick(int i, int c, bit s);
        bit r = 0;
        if (!lvl[i][c]) begin
            if (s) begin
                run[i][c]++;
                if (run[i][c] == SS) begin
                    lvl[i][c] = 1; run[i][c] = 0;
                    rl[i][c] = 0; hld[i][c] = 0; r = 1;
                end
            end else begin
                run[i][c] = 0;
            end
        end else if (s) begin
            if (rl[i][c] > 0) begin
                rl[i][c] = 0;
                hld[i][c] = 0;
            end else begin
                hld[i][c]++;
                if (i == 0 && hld[i][c] >= RD && (hld[i][c] - RD) % RR == 0)
                    r = 1;
            end
        end else begin
            rl[i][c]++;
            if (rl[i][c] == SS) begin
                lvl[i][c] = 0; rl[i][c] = 0; run[i][c] = 0;
            end
        end
        return r;
    endfunction

    function automatic void model_edge(bit inc, bit dec, bit rst);
        bit r [2][2];
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                r[i][c] = 0;
                exp_p[i][c] = 0;
            end
        end
        if (ncyc % TD == TD - 1) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 2; c++) r[i][c] = model_tick(i, c, d2[c]);
                exp_p[i][0] = r[i][0] & ~r[i][1];
                exp_p[i][1] = r[i][1] & ~r[i][0];
            end
        end
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) exp_h[i][c] = lvl[i][c];
        d2 = d1;
        d1[0] = inc;
        d1[1] = dec;
        ncyc++;
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic clr_pc();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) pc[i][c] = 0;
    endtask

    task automatic cyc(bit inc, bit dec, bit rst);
        btn_inc = inc;
        btn_dec = dec;
        reset   = rst;
        @(posedge clk);
        model_edge(inc, dec, rst);
        @(negedge clk);
        chk("rep_inc_pulse", bus0.inc_pulse, exp_p[0][0]);
        chk("rep_dec_pulse", bus0.dec_pulse, exp_p[0][1]);
        chk("rep_inc_held", bus0.inc_held, exp_h[0][0]);
        chk("rep_dec_held", bus0.dec_held, exp_h[0][1]);
        chk("one_inc_pulse", bus1.inc_pulse, exp_p[1][0]);
        chk("one_dec_pulse", bus1.dec_pulse, exp_p[1][1]);
        chk("one_inc_held", bus1.inc_held, exp_h[1][0]);
        chk("one_dec_held", bus1.dec_held, exp_h[1][1]);
        if (bus0.inc_pulse === 1'b1) pc[0][0]++;
        if (bus0.dec_pulse === 1'b1) pc[0][1]++;
        if (bus1.inc_pulse === 1'b1) pc[1][0]++;
        if (bus1.dec_pulse === 1'b1) pc[1][1]++;
    endtask

    task automatic hold(int cycles, bit inc, bit dec);
        repeat (cycles) cyc(inc, dec, 1'b0);
    endtask

    initial begin
        model_reset();
        clr_pc();
        @(negedge clk);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("reset_inc_held", bus0.inc_held, 1'b0);
        hold(7, 0, 0);

        // clean press held 20 ticks
        clr_pc();
        hold(20 * TD, 1, 0);
        chk_int("press_no_dec", pc[0][1], 0);
        hold(6 * TD, 0, 0);

        // bouncing dec: 2 ticks high, 1 tick low, five times
        clr_pc();
        repeat (5) begin
            hold(2 * TD, 0, 1);
            hold(TD, 0, 0);
        end
        chk_int("bounce_rep_dec", pc[0][1], 0);
        chk_int("bounce_one_dec", pc[1][1], 0);
        chk("bounce_dec_held", bus0.dec_held, 1'b0);
        hold(6 * TD, 0, 0);

        // long hold for auto-repeat
        hold(30 * TD, 1, 0);
        hold(6 * TD, 0, 0);

        // both together: accepted together, steps cancelled
        clr_pc();
        hold(5 * TD, 1, 1);
        chk_int("both_inc_none", pc[0][0], 0);
        chk_int("both_dec_none", pc[0][1], 0);
        chk("both_inc_held", bus0.inc_held, 1'b1);
        chk("both_dec_held", bus0.dec_held, 1'b1);
        hold(15 * TD, 1, 0);
        hold(6 * TD, 0, 0);

        // reset while repeating, button still held
        hold(16 * TD, 1, 0);
        cyc(1, 0, 1);
        chk("rst_inc_held", bus0.inc_held, 1'b0);
        clr_pc();
        hold(10, 1, 0);
        chk_int("rst_requalify", pc[0][0], 0);
        hold(20 * TD, 1, 0);
        hold(6 * TD, 0, 0);

        // single-shot build: one pulse, release glitch adds none
        clr_pc();
        hold(40 * TD, 0, 1);
        hold(TD, 0, 0);
        hold(10 * TD, 0, 1);
        hold(6 * TD, 0, 0);
        chk_int("oneshot_dec", pc[1][1], 1);

        // random button activity with occasional resets
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 29) == 0) cyc(0, 0, 1);
            hold(int'($urandom_range(1, 24)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
